regio_arbiter: RTL and testbench

- Shares the single KSZ8851 register-access engine between two requesters: requester 0 is the init/config sequencer, requester 1 is the TX/RX datapath.
- Latches one requester's command, drives the engine's command inputs, and issues a one-cycle-qualified NewCommand.
- Tracks completion through the engine's state output, returns read data, and pulses a per-requester ack.
- Round-robin arbitration with a timeout watchdog. Sits between the requesters and the register-access engine.

---
 rtl/regio_arbiter_if.sv | 51 +++++
 rtl/regio_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_regio_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regio_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regio_arbiter_if
// Description : Bundle between the two register-access requesters, the
//               arbiter and the KSZ8851 register-access engine.
//               slave  - arbiter view (requests and engine status in,
//                        acks, read data and engine command out)
//               master - environment view (requesters plus engine)
//               Requester side: req, req_wr, req_dummy, req_offset0/1,
//                 req_length, req_wdata0/1 -> ack, err, rdata, grant
//               Engine side:    eng_wr, eng_offset, eng_length, eng_wdata,
//                 eng_dummy, eng_new_cmd <- eng_state, eng_rdata
// Revision    : 1.0 - initial release
// ============================================================================
interface regio_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_wr;
  logic [1:0]  req_dummy;
  logic [7:0]  req_offset0;
  logic [7:0]  req_offset1;
  logic [1:0]  req_length;
  logic [15:0] req_wdata0;
  logic [15:0] req_wdata1;
  logic [1:0]  ack;
  logic        err;
  logic [15:0] rdata;
  logic [1:0]  grant;
  logic        eng_wr;
  logic [7:0]  eng_offset;
  logic        eng_length;
  logic [15:0] eng_wdata;
  logic        eng_dummy;
  logic        eng_new_cmd;
  logic [3:0]  eng_state;
  logic [15:0] eng_rdata;

  modport slave (
    input  req, req_wr, req_dummy, req_offset0, req_offset1, req_length,
           req_wdata0, req_wdata1, eng_state, eng_rdata,
    output ack, err, rdata, grant, eng_wr, eng_offset, eng_length,
           eng_wdata, eng_dummy, eng_new_cmd
  );

  modport master (
    output req, req_wr, req_dummy, req_offset0, req_offset1, req_length,
           req_wdata0, req_wdata1, eng_state, eng_rdata,
    input  ack, err, rdata, grant, eng_wr, eng_offset, eng_length,
           eng_wdata, eng_dummy, eng_new_cmd
  );
endinterface
`default_nettype wire

// File: rtl/regio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regio_arbiter
// Description : Round-robin arbiter sharing the KSZ8851 register-access
//               engine between the init/config sequencer (requester 0) and
//               the TX/RX datapath (requester 1). Latches the winner's
//               command, holds NewCommand until the engine leaves Wait,
//               waits for the engine to return to Wait, then acks the
//               owner (with read data). A watchdog aborts with err after
//               TIMEOUT-1 cycles.
// Ports       : clk40m - 40 MHz clock
//               reset  - asynchronous, active-low
//               bus    - regio_arbiter_if.slave (requester + engine side)
// Revision    : 1.0 - initial release
// ============================================================================
module regio_arbiter #(
  parameter int         TIMEOUT   = 64,
  parameter logic [3:0] WAIT_CODE = 4'h9
) (
  input  logic            clk40m,
  input  logic            reset,
  regio_arbiter_if.slave  bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_BUSY  = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  // One spare bit so the increment can never wrap before saturation.
  localparam int              c_CW      = $clog2(TIMEOUT + 1) + 1;
  localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT - 1);

  logic [1:0]      r_state, w_state_n;
  logic            r_last, w_last_n;
  logic [c_CW-1:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic [1:0]      r_ack, w_ack_n;
  logic            r_err, w_err_n;
  logic [15:0]     r_rdata, w_rdata_n;
  logic [1:0]      r_grant, w_grant_n;
  logic            r_eng_wr, w_eng_wr_n;
  logic [7:0]      r_eng_offset, w_eng_offset_n;
  logic            r_eng_length, w_eng_length_n;
  logic [15:0]     r_eng_wdata, w_eng_wdata_n;
  logic            r_eng_dummy, w_eng_dummy_n;
  logic            r_eng_new_cmd, w_eng_new_cmd_n;

  logic            w_pick;
  logic            w_eng_busy;
  logic            w_timeout;

  // Requester to serve: a lone request wins outright; on a tie the one
  // that did not own the engine last time wins.
  always_comb begin
    case (bus.req)
      2'b10:   w_pick = 1'b1;
      2'b11:   w_pick = ~r_last;
      default: w_pick = 1'b0;
    endcase
  end

  assign w_eng_busy = (bus.eng_state != WAIT_CODE);
  assign w_cnt_inc  = r_cnt + c_CW'(1);
  assign w_timeout  = (w_cnt_inc >= c_TO_LAST);

  // State register
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_n;
  end

  // Next-state logic
  always_comb begin
    w_state_n = r_state;
    case (r_state)
      c_ST_IDLE:  if (|bus.req) w_state_n = c_ST_ISSUE;
      c_ST_ISSUE: begin
        if (w_eng_busy)     w_state_n = c_ST_BUSY;
        else if (w_timeout) w_state_n = c_ST_DONE;
      end
      c_ST_BUSY:  if (!w_eng_busy || w_timeout) w_state_n = c_ST_DONE;
      c_ST_DONE:  w_state_n = c_ST_IDLE;
      default:    w_state_n = c_ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_last_n        = r_last;
    w_cnt_n         = r_cnt;
    w_ack_n         = 2'b00;
    w_err_n         = 1'b0;
    w_rdata_n       = r_rdata;
    w_grant_n       = r_grant;
    w_eng_wr_n      = r_eng_wr;
    w_eng_offset_n  = r_eng_offset;
    w_eng_length_n  = r_eng_length;
    w_eng_wdata_n   = r_eng_wdata;
    w_eng_dummy_n   = r_eng_dummy;
    w_eng_new_cmd_n = r_eng_new_cmd;
    case (r_state)
      c_ST_IDLE: begin
        if (|bus.req) begin
          w_grant_n       = w_pick ? 2'b10 : 2'b01;
          w_last_n        = w_pick;
          w_eng_wr_n      = bus.req_wr[w_pick];
          w_eng_dummy_n   = bus.req_dummy[w_pick];
          w_eng_length_n  = bus.req_length[w_pick];
          w_eng_offset_n  = w_pick ? bus.req_offset1 : bus.req_offset0;
          w_eng_wdata_n   = w_pick ? bus.req_wdata1  : bus.req_wdata0;
          w_eng_new_cmd_n = 1'b1;
          w_cnt_n         = '0;
        end
      end
      c_ST_ISSUE: begin
        w_cnt_n = w_timeout ? c_TO_LAST : w_cnt_inc;
        // Hold NewCommand until the engine is seen to have accepted it,
        // then drop it so the engine cannot chain a second command.
        if (w_eng_busy) begin
          w_eng_new_cmd_n = 1'b0;
        end else if (w_timeout) begin
          w_eng_new_cmd_n = 1'b0;
          w_ack_n         = r_grant;
          w_err_n         = 1'b1;
        end
      end
      c_ST_BUSY: begin
        w_cnt_n = w_timeout ? c_TO_LAST : w_cnt_inc;
        if (!w_eng_busy) begin
          w_ack_n = r_grant;
          if (!r_eng_wr) w_rdata_n = bus.eng_rdata;
        end else if (w_timeout) begin
          w_ack_n = r_grant;
          w_err_n = 1'b1;
        end
      end
      c_ST_DONE: w_grant_n = 2'b00;
      default:   w_grant_n = 2'b00;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk40m or negedge reset) begin
    if (!reset) begin
      r_last        <= 1'b1;
      r_cnt         <= '0;
      r_ack         <= 2'b00;
      r_err         <= 1'b0;
      r_rdata       <= 16'h0000;
      r_grant       <= 2'b00;
      r_eng_wr      <= 1'b0;
      r_eng_offset  <= 8'h00;
      r_eng_length  <= 1'b0;
      r_eng_wdata   <= 16'h0000;
      r_eng_dummy   <= 1'b0;
      r_eng_new_cmd <= 1'b0;
    end else begin
      r_last        <= w_last_n;
      r_cnt         <= w_cnt_n;
      r_ack         <= w_ack_n;
      r_err         <= w_err_n;
      r_rdata       <= w_rdata_n;
      r_grant       <= w_grant_n;
      r_eng_wr      <= w_eng_wr_n;
      r_eng_offset  <= w_eng_offset_n;
      r_eng_length  <= w_eng_length_n;
      r_eng_wdata   <= w_eng_wdata_n;
      r_eng_dummy   <= w_eng_dummy_n;
      r_eng_new_cmd <= w_eng_new_cmd_n;
    end
  end

  assign bus.ack         = r_ack;
  assign bus.err         = r_err;
  assign bus.rdata       = r_rdata;
  assign bus.grant       = r_grant;
  assign bus.eng_wr      = r_eng_wr;
  assign bus.eng_offset  = r_eng_offset;
  assign bus.eng_length  = r_eng_length;
  assign bus.eng_wdata   = r_eng_wdata;
  assign bus.eng_dummy   = r_eng_dummy;
  assign bus.eng_new_cmd = r_eng_new_cmd;

endmodule
`default_nettype wire

// File: tb/tb_regio_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regio_arbiter
// Description : Self-checking bench for regio_arbiter. Plays both requesters
//               and a simple engine (leaves Wait when NewCommand is seen,
//               returns after a programmable number of cycles, or sticks in
//               Wait). A transaction-level model predicts every output each
//               cycle; directed steps add hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regio_arbiter;
  localparam int         TIMEOUT   = 64;
  localparam logic [3:0] WAIT_CODE = 4'h9;

  logic clk40m = 1'b0;
  logic reset  = 1'b1;

  regio_arbiter_if bus();

  regio_arbiter #(.TIMEOUT(TIMEOUT), .WAIT_CODE(WAIT_CODE)) dut (
    .clk40m (clk40m),
    .reset  (reset),
    .bus    (bus)
  );

  always #10 clk40m = ~clk40m;

  int n_vec = 0;
  int n_bad = 0;

  // ---------------------------------------------------------------- engine
  bit          eng_stuck  = 1'b0;
  int          eng_busy_n = 6;
  logic [15:0] eng_ret    = 16'h0000;

  initial begin : engine
    int cnt;
    cnt           = 0;
    bus.eng_state = WAIT_CODE;
    bus.eng_rdata = 16'h0000;
    forever begin
      @(negedge clk40m);
      if (!reset) begin
        cnt           = 0;
        bus.eng_state = WAIT_CODE;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        if (cnt == 0) begin
          bus.eng_state = WAIT_CODE;
          bus.eng_rdata = eng_ret;
        end
      end else if (bus.eng_new_cmd && !eng_stuck) begin
        bus.eng_state = 4'h2;
        bus.eng_rdata = 16'hDEAD;
        cnt           = eng_busy_n;
      end
    end
  end

  // ----------------------------------------------------------------- model
  // Tracks one transaction at a time: who owns the engine, how many cycles
  // since grant, whether the engine has been seen to leave Wait, and the
  // single post-ack cycle before a new grant may happen.
  logic [1:0]  exp_ack = '0, exp_grant = '0;
  logic        exp_err = 1'b0, exp_wr = 1'b0, exp_len = 1'b0;
  logic        exp_dummy = 1'b0, exp_new = 1'b0;
  logic [7:0]  exp_off = '0;
  logic [15:0] exp_rdata = '0, exp_wdata = '0;
  int          m_owner = 0, m_age = 0;
  bit          m_active = 0, m_left = 0, m_done = 0, m_last = 1;

  task automatic m_finish(input bit timed_out);
    exp_ack = 2'(1 << m_owner);
    exp_err = timed_out;
    exp_new = 1'b0;
    if (!timed_out && !exp_wr) exp_rdata = bus.eng_rdata;
    m_active = 0;
    m_done   = 1;
  endtask

  always @(posedge clk40m) begin
    if (!reset) begin
      {exp_ack, exp_grant, exp_err, exp_wr, exp_len, exp_dummy, exp_new} = '0;
      exp_off = '0; exp_rdata = '0; exp_wdata = '0;
      m_active = 0; m_done = 0; m_last = 1;
    end else if (m_done) begin
      exp_ack = 2'b00; exp_err = 1'b0; exp_grant = 2'b00; m_done = 0;
    end else if (!m_active) begin
      if (bus.req != 2'b00) begin
        if (bus.req == 2'b11) m_owner = m_last ? 0 : 1;
        else                  m_owner = bus.req[1] ? 1 : 0;
        m_last    = (m_owner == 1);
        exp_grant = 2'(1 << m_owner);
        exp_wr    = bus.req_wr[m_owner];
        exp_dummy = bus.req_dummy[m_owner];
        exp_len   = bus.req_length[m_owner];
        exp_off   = (m_owner == 1) ? bus.req_offset1 : bus.req_offset0;
        exp_wdata = (m_owner == 1) ? bus.req_wdata1  : bus.req_wdata0;
        exp_new   = 1'b1;
        m_active  = 1; m_left = 0; m_age = 0;
      end
    end else begin
      m_age = m_age + 1;
      if (!m_left && bus.eng_state != WAIT_CODE) begin
        m_left  = 1;
        exp_new = 1'b0;
      end else if (m_left && bus.eng_state == WAIT_CODE) begin
        m_finish(1'b0);
      end else if (m_age == TIMEOUT - 1) begin
        m_finish(1'b1);
      end
    end
  end

  // --------------------------------------------------------------- compare
  int cyc = 0;
  always @(posedge clk40m) begin
    #2;
    cyc   = cyc + 1;
    n_vec = n_vec + 1;
    if ({bus.ack, bus.err, bus.rdata, bus.grant, bus.eng_wr, bus.eng_offset,
         bus.eng_length, bus.eng_wdata, bus.eng_dummy, bus.eng_new_cmd} !==
        {exp_ack, exp_err, exp_rdata, exp_grant, exp_wr, exp_off,
         exp_len, exp_wdata, exp_dummy, exp_new}) begin
      n_bad = n_bad + 1;
      $display("FAIL cycle %0d outputs: got ack=%b err=%b rdata=%h grant=%b wr=%b off=%h len=%b wd=%h dm=%b nc=%b; want ack=%b err=%b rdata=%h grant=%b wr=%b off=%h len=%b wd=%h dm=%b nc=%b",
               cyc, bus.ack, bus.err, bus.rdata, bus.grant, bus.eng_wr, bus.eng_offset,
               bus.eng_length, bus.eng_wdata, bus.eng_dummy, bus.eng_new_cmd,
               exp_ack, exp_err, exp_rdata, exp_grant, exp_wr, exp_off,
               exp_len, exp_wdata, exp_dummy, exp_new);
    end
  end

  // --------------------------------------------------------------- helpers
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec = n_vec + 1;
    if (act !== want) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic wait_grant(input int max, output int waited);
    waited = 0;
    while (bus.grant == 2'b00 && waited < max) begin
      @(negedge clk40m);
      waited = waited + 1;
    end
    if (bus.grant == 2'b00) begin
      n_vec = n_vec + 1; n_bad = n_bad + 1;
      $display("FAIL wait_grant: no grant within %0d cycles", max);
    end
  endtask

  task automatic wait_ack(input int max, output int waited);
    waited = 0;
    while (bus.ack == 2'b00 && waited < max) begin
      @(negedge clk40m);
      waited = waited + 1;
    end
    if (bus.ack == 2'b00) begin
      n_vec = n_vec + 1; n_bad = n_bad + 1;
      $display("FAIL wait_ack: no ack within %0d cycles", max);
    end
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin : stim
    int w, g;
    bus.req = 2'b00; bus.req_wr = 2'b00; bus.req_dummy = 2'b00;
    bus.req_offset0 = 8'h00; bus.req_offset1 = 8'h00; bus.req_length = 2'b00;
    bus.req_wdata0 = 16'h0000; bus.req_wdata1 = 16'h0000;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk40m);
    chk("reset grant", 32'(bus.grant), 32'h0);
    chk("reset new_cmd", 32'(bus.eng_new_cmd), 32'h0);
    reset = 1'b1;
    @(negedge clk40m);

    // Single read from requester 0; offset changed after grant must not leak.
    bus.req_offset0 = 8'h10; bus.req_length = 2'b01; bus.req_wr = 2'b00;
    eng_busy_n = 6; eng_ret = 16'hA55A;
    bus.req = 2'b01;
    wait_grant(20, w);
    chk("t1 grant", 32'(bus.grant), 32'h1);
    chk("t1 new_cmd at grant", 32'(bus.eng_new_cmd), 32'h1);
    bus.req_offset0 = 8'h20;
    wait_ack(40, w);
    chk("t1 grant to ack cycles", 32'(w), 32'd7);
    chk("t1 ack", 32'(bus.ack), 32'h1);
    chk("t1 rdata", 32'(bus.rdata), 32'hA55A);
    chk("t1 err", 32'(bus.err), 32'h0);
    chk("t1 offset held", 32'(bus.eng_offset), 32'h10);
    bus.req = 2'b00;
    @(negedge clk40m);

    // Dummy write from requester 1: rdata must keep the previous read.
    bus.req_wr = 2'b10; bus.req_dummy = 2'b10; bus.req_wdata1 = 16'h1234;
    bus.req_offset1 = 8'h30; bus.req_length = 2'b00; eng_ret = 16'hBEEF;
    bus.req = 2'b10;
    wait_grant(20, w);
    chk("t2 eng_wdata", 32'(bus.eng_wdata), 32'h1234);
    chk("t2 eng_dummy", 32'(bus.eng_dummy), 32'h1);
    wait_ack(40, w);
    chk("t2 ack", 32'(bus.ack), 32'h2);
    chk("t2 rdata unchanged", 32'(bus.rdata), 32'hA55A);
    bus.req = 2'b00; bus.req_wr = 2'b00; bus.req_dummy = 2'b00;
    @(negedge clk40m);

    // Contention: both held, grants alternate 0,1,0,1 with 2-cycle gaps.
    eng_ret = 16'h0F0F;
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, w);
      chk($sformatf("t3 ack %0d", k), 32'(bus.ack), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k < 3) begin
        @(negedge clk40m);
        g = 1;
        wait_grant(10, w);
        chk($sformatf("t3 gap %0d", k), 32'(g + w), 32'd2);
        chk($sformatf("t3 grant %0d", k + 1), 32'(bus.grant), (k % 2 == 0) ? 32'h2 : 32'h1);
      end
    end
    bus.req = 2'b00;
    @(negedge clk40m);

    // Engine stuck in Wait: abort with err 63 cycles after grant.
    eng_stuck = 1'b1;
    bus.req = 2'b01;
    wait_grant(20, w);
    wait_ack(100, w);
    chk("t4 grant to abort cycles", 32'(w), 32'd63);
    chk("t4 ack", 32'(bus.ack), 32'h1);
    chk("t4 err", 32'(bus.err), 32'h1);
    chk("t4 new_cmd", 32'(bus.eng_new_cmd), 32'h0);
    chk("t4 rdata unchanged", 32'(bus.rdata), 32'h0F0F);
    bus.req = 2'b00; eng_stuck = 1'b0;
    @(negedge clk40m);
    chk("t4 err one cycle", 32'(bus.err), 32'h0);
    eng_ret = 16'h5AA5;
    bus.req = 2'b01;
    wait_ack(40, w);
    chk("t4 recovery err", 32'(bus.err), 32'h0);
    chk("t4 recovery rdata", 32'(bus.rdata), 32'h5AA5);
    bus.req = 2'b00;
    @(negedge clk40m);

    // Reset in BUSY: everything clears at once, then requester 1 is served.
    eng_busy_n = 20; eng_ret = 16'h7777;
    bus.req = 2'b01;
    wait_grant(20, w);
    repeat (3) @(negedge clk40m);
    chk("t5 in busy", 32'({bus.grant, bus.eng_new_cmd}), 32'h2);
    reset = 1'b0;
    #1;
    chk("t5 reset outputs", 32'({bus.grant, bus.ack, bus.eng_offset, bus.eng_new_cmd}), 32'h0);
    chk("t5 reset rdata", 32'(bus.rdata), 32'h0);
    bus.req = 2'b00;
    repeat (2) @(negedge clk40m);
    reset = 1'b1;
    eng_busy_n = 4;
    bus.req = 2'b10;
    wait_grant(20, w);
    chk("t5 first grant", 32'(bus.grant), 32'h2);
    wait_ack(40, w);
    chk("t5 ack", 32'(bus.ack), 32'h2);
    bus.req = 2'b00;
    repeat (3) @(negedge clk40m);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
